mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single pipelined main-memory port between the instruction cache (read-only) and the data cache (read/write).
- Accepts at most one request per cycle and registers it onto the memory request bus.
- Tracks in-flight reads against a credit limit.
- Steers returning line data to the correct requester using the memory's is_instr tag.
- Generates a delayed write acknowledge to the data cache.

Parameters:
- ADDR_WIDTH, params_pkg::ADDR_WIDTH, address width
- DATA_WIDTH, 128, cache line width in bits
- MAX_OUTSTANDING, 10, maximum reads in flight (memory read pipeline depth)
- WR_ACK_LAT, 5, cycles from write issue on the memory bus to ic/dc write acknowledge

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- ic_req_valid_i  in  1  icache read request
- ic_addr_i  in  ADDR_WIDTH  icache line address
- ic_req_ready_o  out  1  icache request accepted this cycle
- ic_rsp_valid_o  out  1  icache line return
- ic_rsp_data_o  out  DATA_WIDTH  icache line data
- dc_req_valid_i  in  1  dcache request
- dc_req_wr_i  in  1  1 = write, 0 = read
- dc_addr_i  in  ADDR_WIDTH  dcache line address
- dc_wr_data_i  in  DATA_WIDTH  dcache write line
- dc_access_size_i  in  access_size_t  access size
- dc_req_ready_o  out  1  dcache request accepted this cycle
- dc_rsp_valid_o  out  1  dcache read line return
- dc_rsp_data_o  out  DATA_WIDTH  dcache line data
- dc_wr_ack_o  out  1  one-cycle write-complete pulse
- mem_rd_req_valid_o  out  1  memory read request
- mem_wr_req_valid_o  out  1  memory write request
- mem_req_is_instr_o  out  1  request tag
- mem_address_o  out  ADDR_WIDTH  memory address
- mem_wr_data_o  out  DATA_WIDTH  memory write data
- mem_access_size_o  out  access_size_t  memory access size
- mem_data_valid_i  in  1  memory read return
- mem_data_is_instr_i  in  1  return tag
- mem_data_i  in  DATA_WIDTH  returned line

Behaviour:
- Reset (async, rst_i=1):
  - All outputs 0.
  - Credit count 0.
  - Round-robin pointer selects icache.
  - Write-ack shift register cleared.
  - A request in the issue register is dropped; in-flight returns after reset are ignored until credits are rebuilt.
- Eligibility:
  - ic eligible = ic_req_valid_i && credits < MAX_OUTSTANDING.
  - dc write is always eligible.
  - dc read eligible = credits < MAX_OUTSTANDING.
- Arbitration: round-robin between eligible requesters.
  - Pointer moves to the non-granted side after each grant.
  - A single eligible requester always wins.
- ready is combinational. Exactly one of ic_req_ready_o / dc_req_ready_o is high per cycle, or neither. Requesters hold valid and payload until ready.
- Issue register: the granted request appears on the mem_* outputs the next cycle (1-cycle latency), for exactly 1 cycle.
  - mem_rd_req_valid_o and mem_wr_req_valid_o are never both 1.
  - icache requests drive mem_req_is_instr_o=1 and mem_access_size_o = the line-size value of access_size_t.
- Credits:
  - +1 when a read is granted, -1 on mem_data_valid_i.
  - Simultaneous grant and return leaves the count unchanged.
  - The count never exceeds MAX_OUTSTANDING and never underflows; a return with count 0 is ignored.
- Response routing (combinational, 0-cycle):
  - mem_data_valid_i && mem_data_is_instr_i gives ic_rsp_valid_o.
  - mem_data_valid_i && !mem_data_is_instr_i gives dc_rsp_valid_o.
  - Both data outputs are driven by mem_data_i.
- Write acknowledge: a WR_ACK_LAT-deep shift register is loaded when mem_wr_req_valid_o=1. dc_wr_ack_o pulses exactly WR_ACK_LAT cycles after that cycle. Back-to-back writes give back-to-back acks.
- Ordering: the memory is in-order, so a dc read issued after a dc write to the same address returns the new data. The arbiter adds no hazard stall.
- Full boundary: at credits == MAX_OUTSTANDING, reads stall and writes still proceed. Reads resume in the same cycle a return is seen.

Optional Feature:
MEM_ARB_PERF_EN:
- Defined: adds 32-bit saturating counters, exposed as extra outputs, all reset to 0:
  - perf_ic_grants_o
  - perf_dc_grants_o
  - perf_credit_stall_o (cycles with any valid read blocked by credits)
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset, then ic read 0x40 alone:
  - ic_req_ready_o the same cycle.
  - Next cycle: mem_rd_req_valid_o=1, address 0x40, is_instr=1.
  - Returned data 0xA5..A5 with tag 1 appears on ic_rsp_data_o, and dc_rsp_valid_o stays 0.
- ic and dc reads held valid together for 4 cycles: grants alternate ic, dc, ic, dc; every grant is followed by exactly one mem_rd_req_valid_o pulse.
- 10 dc reads with no returns: the 11th read is stalled (dc_req_ready_o=0), and a dc write is still accepted. One mem_data_valid_i re-enables the read in the same cycle.
- dc write to 0x80 at cycle T: mem_wr_req_valid_o at T+1, then a single dc_wr_ack_o pulse at T+6 with WR_ACK_LAT=5.
- Credit count 3, grant and return in the same cycle: count stays 3, with no extra stall.
- Assert rst_i with 5 credits and a pending write ack: all outputs are 0 immediately, and no ack follows after release.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bundle of cache request/response and main-memory bus signals around mem_arbiter.
// Access sizes are coded in SIZE_WIDTH bits; a full cache line uses code 4.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 128,
  parameter int SIZE_WIDTH = 3
);
  logic                  ic_req_valid;
  logic [ADDR_WIDTH-1:0] ic_addr;
  logic                  ic_req_ready;
  logic                  ic_rsp_valid;
  logic [DATA_WIDTH-1:0] ic_rsp_data;

  logic                  dc_req_valid;
  logic                  dc_req_wr;
  logic [ADDR_WIDTH-1:0] dc_addr;
  logic [DATA_WIDTH-1:0] dc_wr_data;
  logic [SIZE_WIDTH-1:0] dc_access_size;
  logic                  dc_req_ready;
  logic                  dc_rsp_valid;
  logic [DATA_WIDTH-1:0] dc_rsp_data;
  logic                  dc_wr_ack;

  logic                  mem_rd_req_valid;
  logic                  mem_wr_req_valid;
  logic                  mem_req_is_instr;
  logic [ADDR_WIDTH-1:0] mem_address;
  logic [DATA_WIDTH-1:0] mem_wr_data;
  logic [SIZE_WIDTH-1:0] mem_access_size;
  logic                  mem_data_valid;
  logic                  mem_data_is_instr;
  logic [DATA_WIDTH-1:0] mem_data;

  // Arbiter side
  modport slave (
    input  ic_req_valid, ic_addr,
    output ic_req_ready, ic_rsp_valid, ic_rsp_data,
    input  dc_req_valid, dc_req_wr, dc_addr, dc_wr_data, dc_access_size,
    output dc_req_ready, dc_rsp_valid, dc_rsp_data, dc_wr_ack,
    output mem_rd_req_valid, mem_wr_req_valid, mem_req_is_instr,
    output mem_address, mem_wr_data, mem_access_size,
    input  mem_data_valid, mem_data_is_instr, mem_data
  );

  // Caches and memory side
  modport master (
    output ic_req_valid, ic_addr,
    input  ic_req_ready, ic_rsp_valid, ic_rsp_data,
    output dc_req_valid, dc_req_wr, dc_addr, dc_wr_data, dc_access_size,
    input  dc_req_ready, dc_rsp_valid, dc_rsp_data, dc_wr_ack,
    input  mem_rd_req_valid, mem_wr_req_valid, mem_req_is_instr,
    input  mem_address, mem_wr_data, mem_access_size,
    output mem_data_valid, mem_data_is_instr, mem_data
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin icache/dcache arbiter for one pipelined memory port, with read credits and write acks.
// Optional MEM_ARB_PERF_EN adds saturating grant and credit-stall counters.
module mem_arbiter #(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 128,
  parameter int                    MAX_OUTSTANDING = 10,
  parameter int                    WR_ACK_LAT      = 5,
  parameter int                    SIZE_WIDTH      = 3,
  parameter logic [SIZE_WIDTH-1:0] SIZE_LINE       = 3'd4
) (
  input  logic               clk,
  input  logic               rst,
  mem_arbiter_if.slave       bus
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_ic_grants,
  output logic [31:0]        perf_dc_grants,
  output logic [31:0]        perf_credit_stall
`endif
);
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(MAX_OUTSTANDING);

  logic [CW-1:0]         credits;
  logic                  rr_dc;
  logic [WR_ACK_LAT-1:0] ack_sr;

  logic                  ret;
  logic                  rd_ok;
  logic                  ic_elig;
  logic                  dc_elig;
  logic                  grant_ic;
  logic                  grant_dc;
  logic                  rd_grant;
  logic [ADDR_WIDTH-1:0] nxt_addr;
  logic [DATA_WIDTH-1:0] nxt_wdata;
  logic [SIZE_WIDTH-1:0] nxt_size;

  // A return frees its credit in the same cycle, so a full arbiter can still grant a read.
  always_comb begin
    ret      = bus.mem_data_valid && (credits != '0);
    rd_ok    = (credits < CREDIT_MAX) || ret;
    ic_elig  = !rst && bus.ic_req_valid && rd_ok;
    dc_elig  = !rst && bus.dc_req_valid && (bus.dc_req_wr || rd_ok);
    grant_ic = ic_elig && !(dc_elig && rr_dc);
    grant_dc = dc_elig && !grant_ic;
    rd_grant = grant_ic || (grant_dc && !bus.dc_req_wr);

    nxt_addr  = '0;
    nxt_wdata = '0;
    nxt_size  = '0;
    if (grant_ic) begin
      nxt_addr = bus.ic_addr;
      nxt_size = SIZE_LINE;
    end else if (grant_dc) begin
      nxt_addr  = bus.dc_addr;
      nxt_wdata = bus.dc_wr_data;
      nxt_size  = bus.dc_access_size;
    end
  end

  assign bus.ic_req_ready = grant_ic;
  assign bus.dc_req_ready = grant_dc;
  assign bus.ic_rsp_valid = ret && bus.mem_data_is_instr;
  assign bus.dc_rsp_valid = ret && !bus.mem_data_is_instr;
  assign bus.ic_rsp_data  = rst ? '0 : bus.mem_data;
  assign bus.dc_rsp_data  = rst ? '0 : bus.mem_data;
  assign bus.dc_wr_ack    = ack_sr[WR_ACK_LAT-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.mem_rd_req_valid <= 1'b0;
      bus.mem_wr_req_valid <= 1'b0;
      bus.mem_req_is_instr <= 1'b0;
      bus.mem_address      <= '0;
      bus.mem_wr_data      <= '0;
      bus.mem_access_size  <= '0;
      credits              <= '0;
      rr_dc                <= 1'b0;
      ack_sr               <= '0;
    end else begin
      bus.mem_rd_req_valid <= rd_grant;
      bus.mem_wr_req_valid <= grant_dc && bus.dc_req_wr;
      bus.mem_req_is_instr <= grant_ic;
      bus.mem_address      <= nxt_addr;
      bus.mem_wr_data      <= nxt_wdata;
      bus.mem_access_size  <= nxt_size;

      if (grant_ic)      rr_dc <= 1'b1;
      else if (grant_dc) rr_dc <= 1'b0;

      case ({rd_grant, ret})
        2'b10:   credits <= credits + CW'(1);
        2'b01:   credits <= credits - CW'(1);
        default: credits <= credits;
      endcase

      ack_sr <= (ack_sr << 1) | WR_ACK_LAT'(bus.mem_wr_req_valid);
    end
  end

`ifdef MEM_ARB_PERF_EN
  logic rd_stall;
  assign rd_stall = !rd_ok && (bus.ic_req_valid || (bus.dc_req_valid && !bus.dc_req_wr));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_ic_grants    <= '0;
      perf_dc_grants    <= '0;
      perf_credit_stall <= '0;
    end else begin
      if (grant_ic && !(&perf_ic_grants))   perf_ic_grants    <= perf_ic_grants + 32'd1;
      if (grant_dc && !(&perf_dc_grants))   perf_dc_grants    <= perf_dc_grants + 32'd1;
      if (rd_stall && !(&perf_credit_stall)) perf_credit_stall <= perf_credit_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes per-cycle, memory-bus and ack expectations
// from a queue-based reference model; a negedge monitor pops and compares.
module tb_mem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 128;
  localparam int SW   = 3;
  localparam int MAXO = 10;
  localparam int LAT  = 5;
  localparam logic [SW-1:0] LINE = 3'd4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SIZE_WIDTH(SW)) bus ();

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_ic, perf_dc, perf_stall;
`endif

  mem_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO),
    .WR_ACK_LAT(LAT), .SIZE_WIDTH(SW), .SIZE_LINE(LINE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef MEM_ARB_PERF_EN
    ,
    .perf_ic_grants    (perf_ic),
    .perf_dc_grants    (perf_dc),
    .perf_credit_stall (perf_stall)
`endif
  );

  typedef struct {
    int            cyc;
    logic          rd;
    logic          wr;
    logic          instr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] size;
  } mem_exp_t;

  typedef struct {
    logic          ic_rdy;
    logic          dc_rdy;
    logic          ic_rsp;
    logic          dc_rsp;
    logic [DW-1:0] data;
  } cyc_exp_t;

  mem_exp_t mem_q[$];
  cyc_exp_t cyc_q[$];
  int       ack_q[$];
  bit       tags_q[$];      // tags of reads in flight, oldest first; size is the credit count
  bit       last_was_dc = 1'b1;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Drives one cycle of stimulus, applies the reference rules, then advances to the next cycle.
  task automatic step(input logic ic_v, input logic [AW-1:0] ic_a,
                      input logic dc_v, input logic dc_wr, input logic [AW-1:0] dc_a,
                      input logic [DW-1:0] dc_d, input logic [SW-1:0] dc_sz,
                      input logic mdv, input logic [DW-1:0] mdata,
                      output logic g_ic, output logic g_dc);
    bit mtag, ret, room, ic_e, dc_e;
    mtag = (tags_q.size() > 0) ? tags_q[0] : 1'($urandom_range(0, 1));
    bus.ic_req_valid      = ic_v;
    bus.ic_addr           = ic_a;
    bus.dc_req_valid      = dc_v;
    bus.dc_req_wr         = dc_wr;
    bus.dc_addr           = dc_a;
    bus.dc_wr_data        = dc_d;
    bus.dc_access_size    = dc_sz;
    bus.mem_data_valid    = mdv;
    bus.mem_data_is_instr = mtag;
    bus.mem_data          = mdata;

    ret  = mdv && (tags_q.size() > 0);
    room = (tags_q.size() < MAXO) || ret;
    ic_e = ic_v && room;
    dc_e = dc_v && (dc_wr || room);
    if (ic_e && dc_e) begin
      g_ic = last_was_dc;
      g_dc = !last_was_dc;
    end else begin
      g_ic = ic_e;
      g_dc = dc_e;
    end
    cyc_q.push_back('{g_ic, g_dc, ret && mtag, ret && !mtag, mdata});
    if (ret) void'(tags_q.pop_front());
    if (g_ic) begin
      mem_q.push_back('{cyc + 1, 1'b1, 1'b0, 1'b1, ic_a, '0, LINE});
      tags_q.push_back(1'b1);
      last_was_dc = 1'b0;
    end
    if (g_dc) begin
      mem_q.push_back('{cyc + 1, !dc_wr, dc_wr, 1'b0, dc_a, dc_d, dc_sz});
      if (dc_wr) ack_q.push_back(cyc + 1 + LAT);
      else       tags_q.push_back(1'b0);
      last_was_dc = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic gi, gd;
    for (int i = 0; i < n; i++) step(0, '0, 0, 0, '0, '0, '0, 0, '0, gi, gd);
  endtask

  task automatic drain();
    logic gi, gd;
    for (int i = 0; i < 4 * MAXO && tags_q.size() > 0; i++)
      step(0, '0, 0, 0, '0, '0, '0, 1, {$urandom, $urandom, $urandom, $urandom}, gi, gd);
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_ic_req_ready"}, bus.ic_req_ready, 1'b0);
    check({tag, "_dc_req_ready"}, bus.dc_req_ready, 1'b0);
    check({tag, "_mem_rd"},       bus.mem_rd_req_valid, 1'b0);
    check({tag, "_mem_wr"},       bus.mem_wr_req_valid, 1'b0);
    check({tag, "_mem_addr"},     bus.mem_address, '0);
    check({tag, "_wr_ack"},       bus.dc_wr_ack, 1'b0);
    check({tag, "_ic_rsp_valid"}, bus.ic_rsp_valid, 1'b0);
    check({tag, "_dc_rsp_valid"}, bus.dc_rsp_valid, 1'b0);
  endtask

  // Monitor
  cyc_exp_t mon_e;
  mem_exp_t mon_m;
  bit       mon_ack;
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (cyc_q.size() == 0) begin
          total++;
          $display("FAIL cycle_expectation: none queued for cycle %0d", cyc);
        end else begin
          mon_e = cyc_q.pop_front();
          check("ic_req_ready", bus.ic_req_ready, mon_e.ic_rdy);
          check("dc_req_ready", bus.dc_req_ready, mon_e.dc_rdy);
          check("ic_rsp_valid", bus.ic_rsp_valid, mon_e.ic_rsp);
          check("dc_rsp_valid", bus.dc_rsp_valid, mon_e.dc_rsp);
          if (mon_e.ic_rsp) check("ic_rsp_data", bus.ic_rsp_data, mon_e.data);
          if (mon_e.dc_rsp) check("dc_rsp_data", bus.dc_rsp_data, mon_e.data);
        end
        if (mem_q.size() > 0 && mem_q[0].cyc == cyc) begin
          mon_m = mem_q.pop_front();
          check("mem_rd_req_valid", bus.mem_rd_req_valid, mon_m.rd);
          check("mem_wr_req_valid", bus.mem_wr_req_valid, mon_m.wr);
          check("mem_req_is_instr", bus.mem_req_is_instr, mon_m.instr);
          check("mem_address",      bus.mem_address, mon_m.addr);
          check("mem_access_size",  bus.mem_access_size, mon_m.size);
          if (mon_m.wr) check("mem_wr_data", bus.mem_wr_data, mon_m.wdata);
        end else begin
          check("mem_rd_idle", bus.mem_rd_req_valid, 1'b0);
          check("mem_wr_idle", bus.mem_wr_req_valid, 1'b0);
        end
        mon_ack = (ack_q.size() > 0) && (ack_q[0] == cyc);
        if (mon_ack) void'(ack_q.pop_front());
        check("dc_wr_ack", bus.dc_wr_ack, mon_ack);
      end
    end
  end

  // Stimulus
  logic          gi, gd;
  logic [AW-1:0] ia, da;
  logic          ric_v, rdc_v, rdc_wr;
  logic [AW-1:0] ric_a, rdc_a;
  logic [DW-1:0] rdc_d;
  logic [SW-1:0] rdc_sz;
  logic          rmdv;

  initial begin
    bus.ic_req_valid      = 1'b1;
    bus.ic_addr           = 32'h40;
    bus.dc_req_valid      = 1'b1;
    bus.dc_req_wr         = 1'b0;
    bus.dc_addr           = 32'h80;
    bus.dc_wr_data        = '0;
    bus.dc_access_size    = '0;
    bus.mem_data_valid    = 1'b1;
    bus.mem_data_is_instr = 1'b1;
    bus.mem_data          = '1;
    #12;
    check_quiet_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Lone icache read and its tagged return
    step(1, 32'h40, 0, 0, '0, '0, '0, 0, '0, gi, gd);
    idle(2);
    step(0, '0, 0, 0, '0, '0, '0, 1, {16{8'hA5}}, gi, gd);

    // Put the pointer back on icache, then contend for four cycles
    step(0, '0, 1, 0, 32'h300, '0, 3'd2, 0, '0, gi, gd);
    ia = 32'h100;
    da = 32'h200;
    for (int k = 0; k < 4; k++) begin
      step(1, ia, 1, 0, da, '0, 3'd2, 0, '0, gi, gd);
      if (gi) ia += 32'h10;
      if (gd) da += 32'h10;
    end
    drain();

    // Fill all credits, stall, write still passes, return re-opens reads
    for (int k = 0; k < MAXO; k++) step(0, '0, 1, 0, 32'h1000 + 32'(k * 16), '0, LINE, 0, '0, gi, gd);
    step(0, '0, 1, 0, 32'h1100, '0, LINE, 0, '0, gi, gd);
    step(0, '0, 1, 1, 32'h2000, {4{32'hCAFE_F00D}}, LINE, 0, '0, gi, gd);
    step(0, '0, 1, 0, 32'h1100, '0, LINE, 1, {4{$urandom}}, gi, gd);
    drain();
    idle(LAT + 1);

    // Single write and its delayed ack, then back-to-back writes
    step(0, '0, 1, 1, 32'h80, {4{32'h1234_5678}}, LINE, 0, '0, gi, gd);
    idle(LAT + 2);
    for (int k = 0; k < 3; k++) step(0, '0, 1, 1, 32'h90 + 32'(k * 16), {4{$urandom}}, 3'd1, 0, '0, gi, gd);
    idle(LAT + 2);

    // Grant and return together at three credits, then prove the count by refilling
    for (int k = 0; k < 3; k++) step(1, 32'h400 + 32'(k * 16), 0, 0, '0, '0, '0, 0, '0, gi, gd);
    step(1, 32'h500, 0, 0, '0, '0, '0, 1, {4{$urandom}}, gi, gd);
    for (int k = 0; k < MAXO - 3; k++) step(1, 32'h600 + 32'(k * 16), 0, 0, '0, '0, '0, 0, '0, gi, gd);
    step(1, 32'h700, 0, 0, '0, '0, '0, 0, '0, gi, gd);
    drain();

    // Randomised traffic honouring the hold-until-ready rule
    ric_v = 1'b0;
    rdc_v = 1'b0;
    ric_a = '0; rdc_a = '0; rdc_d = '0; rdc_sz = '0; rdc_wr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!ric_v && $urandom_range(0, 2) != 0) begin
        ric_v = 1'b1;
        ric_a = $urandom & ~32'hF;
      end
      if (!rdc_v && $urandom_range(0, 2) != 0) begin
        rdc_v  = 1'b1;
        rdc_wr = ($urandom_range(0, 3) == 0);
        rdc_a  = $urandom & ~32'hF;
        rdc_d  = {$urandom, $urandom, $urandom, $urandom};
        rdc_sz = 3'($urandom_range(0, 4));
      end
      rmdv = (tags_q.size() > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 19) == 0);
      step(ric_v, ric_a, rdc_v, rdc_wr, rdc_a, rdc_d, rdc_sz, rmdv,
           {$urandom, $urandom, $urandom, $urandom}, gi, gd);
      if (gi) ric_v = 1'b0;
      if (gd) rdc_v = 1'b0;
    end
    drain();
    idle(LAT + 2);

    // Reset with five credits and an ack pending
    for (int k = 0; k < 5; k++) step(0, '0, 1, 0, 32'h3000 + 32'(k * 16), '0, LINE, 0, '0, gi, gd);
    step(0, '0, 1, 1, 32'h3100, {4{32'hDEAD_BEEF}}, LINE, 0, '0, gi, gd);
    idle(1);
    bus.ic_req_valid   = 1'b1;
    bus.dc_req_valid   = 1'b1;
    bus.dc_req_wr      = 1'b0;
    bus.mem_data_valid = 1'b1;
    rst = 1'b1;
    #1;
    check_quiet_outputs("rst_async");
    tags_q.delete();
    mem_q.delete();
    ack_q.delete();
    cyc_q.delete();
    last_was_dc = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < LAT + 3; k++) step(0, '0, 0, 0, '0, '0, '0, 1, {4{$urandom}}, gi, gd);
    step(1, 32'h5000, 1, 0, 32'h6000, '0, LINE, 0, '0, gi, gd);
    step(0, '0, 1, 0, 32'h6000, '0, LINE, 0, '0, gi, gd);
    drain();
    idle(LAT + 2);

    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    check("ack_q_drained", 32'(ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
